// File: rtl/eda_pkg.sv
// Shared types and helpers for the window-compare block: FSM states,
// default geometry and a lowest-set-bit priority encoder.
package eda_pkg;

  localparam int unsigned DEF_PIXEL_WIDTH = 8;
  localparam int unsigned DEF_WIN_K       = 3;
  localparam int unsigned MAX_NEIGH       = 48;
  localparam int unsigned MAX_IDX_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [MAX_NEIGH-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(MAX_NEIGH) - 1; i >= 0; i--) begin
      if (v[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/eda_max_tree.sv
// Binary unsigned max tree over N pixels, zero-padded to a power of two.
// PIPE inserts one register stage at the middle level of the tree.
module eda_max_tree #(
  parameter int unsigned N           = 8,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter bit          PIPE        = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N*PIXEL_WIDTH-1:0] values,
  output logic [PIXEL_WIDTH-1:0]   max_value
);

  localparam int unsigned LEVELS = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LEAVES = 1 << LEVELS;
  localparam int unsigned MID    = LEVELS / 2;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT = LEAVES >> l;
    logic [CNT*PIXEL_WIDTH-1:0] v;

    if (l == 0) begin : g_in
      assign v = (CNT*PIXEL_WIDTH)'(values);
    end else begin : g_max
      logic [CNT*PIXEL_WIDTH-1:0] m;
      for (genvar k = 0; k < CNT; k++) begin : g_k
        logic [PIXEL_WIDTH-1:0] a;
        logic [PIXEL_WIDTH-1:0] b;
        assign a = g_lvl[l-1].v[(2*k)*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign b = g_lvl[l-1].v[(2*k+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
        assign m[k*PIXEL_WIDTH +: PIXEL_WIDTH] = (a >= b) ? a : b;
      end
      if (PIPE && (l == MID)) begin : g_reg
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) v <= '0;
          else          v <= m;
        end
      end else begin : g_comb
        assign v = m;
      end
    end
  end

  if (!PIPE) begin : g_nopipe
    logic unused_clk;
    assign unused_clk = clk ^ reset_n;
  end

  assign max_value = g_lvl[LEVELS].v;

endmodule

// File: rtl/eda_window_compare.sv
// Regional-max window compare with a push queue for equal-valued neighbours.
// Define EDA_WINDOW_COMPARE_PIPE_EN to register the max tree mid-way (+1 cycle).
module eda_window_compare
  import eda_pkg::*;
#(
  parameter  int unsigned PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter  int unsigned WIN_K        = DEF_WIN_K,
  localparam int unsigned WINDOW_WIDTH = WIN_K * WIN_K,
  localparam int unsigned NEIGH        = WINDOW_WIDTH - 1,
  localparam int unsigned CENTER       = (WINDOW_WIDTH - 1) / 2,
  localparam int unsigned IDX_W        = $clog2(NEIGH)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [NEIGH-1:0]                    neigh_addr_valid,
  input  logic [NEIGH-1:0]                    iterated_idx,
  input  logic                                flush,
  output logic                                out_valid,
  output logic                                compare_out,
  output logic [NEIGH-1:0]                    equal_positions,
  output logic                                push_valid,
  output logic [IDX_W-1:0]                    push_idx,
  input  logic                                push_ready
);

`ifdef EDA_WINDOW_COMPARE_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  state_t                              state;
  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] win_q;
  logic [NEIGH-1:0]                    valid_q;
  logic [NEIGH-1:0]                    pending;
  logic                                calc_stage;

  logic [PIXEL_WIDTH-1:0]       centre;
  logic [PIXEL_WIDTH-1:0]       nb;
  logic [NEIGH*PIXEL_WIDTH-1:0] leaves;
  logic [NEIGH-1:0]             eq_c;
  logic [PIXEL_WIDTH-1:0]       max_c;
  logic                         cmp_c;
  logic                         calc_done;
  logic [NEIGH-1:0]             avail;
  logic [NEIGH-1:0]             fire_mask;

  // Neighbours skip the centre position; invalid ones feed 0 into the tree.
  always_comb begin
    leaves = '0;
    eq_c   = '0;
    nb     = '0;
    centre = win_q[CENTER*PIXEL_WIDTH +: PIXEL_WIDTH];
    for (int j = 0; j < int'(NEIGH); j++) begin
      if (j < int'(CENTER)) nb = win_q[j*PIXEL_WIDTH +: PIXEL_WIDTH];
      else                  nb = win_q[(j+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
      if (valid_q[j]) begin
        leaves[j*PIXEL_WIDTH +: PIXEL_WIDTH] = nb;
        eq_c[j] = (nb == centre);
      end
    end
  end

  eda_max_tree #(
    .N           (NEIGH),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .PIPE        (PIPE_EN)
  ) u_max_tree (
    .clk       (clk),
    .reset_n   (reset_n),
    .values    (leaves),
    .max_value (max_c)
  );

  assign cmp_c     = (centre >= max_c);
  assign calc_done = (calc_stage == PIPE_EN);

  // Push side follows the live iterated mask so a stalled index can advance.
  assign avail      = pending & ~iterated_idx;
  assign push_valid = (state == ST_PUSH) && (|avail);
  assign push_idx   = IDX_W'(lowest_set(MAX_NEIGH'(avail)));
  assign fire_mask  = (push_valid && push_ready) ? (NEIGH'(1) << push_idx) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      in_ready        <= 1'b1;
      out_valid       <= 1'b0;
      compare_out     <= 1'b0;
      equal_positions <= '0;
      pending         <= '0;
      calc_stage      <= 1'b0;
      win_q           <= '0;
      valid_q         <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state    <= ST_IDLE;
        pending  <= '0;
        in_ready <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_valid && in_ready) begin
              win_q      <= window_values;
              valid_q    <= neigh_addr_valid;
              calc_stage <= 1'b0;
              in_ready   <= 1'b0;
              state      <= ST_CALC;
            end
          end
          ST_CALC: begin
            if (calc_done) begin
              out_valid       <= 1'b1;
              compare_out     <= cmp_c;
              equal_positions <= eq_c;
              pending         <= eq_c;
              state           <= ST_PUSH;
            end else begin
              calc_stage <= 1'b1;
            end
          end
          ST_PUSH: begin
            if (pending == '0) begin
              state    <= ST_IDLE;
              in_ready <= 1'b1;
            end else begin
              pending <= pending & ~iterated_idx & ~fire_mask;
            end
          end
          default: begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eda_window_compare.sv
// Scoreboard bench for eda_window_compare (K=3, 8-bit pixels): directed
// scenarios plus randomized windows against a behavioural reference.
module tb_eda_window_compare;

  localparam int PW  = 8;
  localparam int NB  = 8;
  localparam int CTR = 4;
`ifdef EDA_WINDOW_COMPARE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] window_values;
  logic [7:0]  neigh_addr_valid;
  logic [7:0]  iterated_idx;
  logic        flush;
  logic        out_valid;
  logic        compare_out;
  logic [7:0]  equal_positions;
  logic        push_valid;
  logic [2:0]  push_idx;
  logic        push_ready;

  typedef struct {
    logic       cmp;
    logic [7:0] eq;
    logic [7:0] push;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] pix [9];
  bit         rand_ready;

  eda_window_compare dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .window_values    (window_values),
    .neigh_addr_valid (neigh_addr_valid),
    .iterated_idx     (iterated_idx),
    .flush            (flush),
    .out_valid        (out_valid),
    .compare_out      (compare_out),
    .equal_positions  (equal_positions),
    .push_valid       (push_valid),
    .push_idx         (push_idx),
    .push_ready       (push_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Reference: max over valid neighbours, equal mask, pushes ascending.
  function automatic exp_t model(input logic [71:0] w, input logic [7:0] nv,
                                 input logic [7:0] it, input logic [7:0] keep);
    exp_t e;
    logic [7:0] c, v, mx;
    int p;
    c = w[CTR*PW +: PW];
    mx = 8'd0;
    e.eq = 8'd0;
    for (int j = 0; j < NB; j++) begin
      p = (j < CTR) ? j : j + 1;
      v = w[p*PW +: PW];
      if (nv[j]) begin
        if (v > mx) mx = v;
        if (v == c) e.eq[j] = 1'b1;
      end
    end
    e.cmp  = (c >= mx);
    e.push = e.eq & ~it & keep;
    e.acc  = 0;
    return e;
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [71:0] pack_pix();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = pix[i];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) push_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic wait_push();
    int n;
    n = 0;
    @(negedge clk);
    while (!push_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!push_valid) check("push_valid_timeout", push_valid, 1);
  endtask

  task automatic send(input logic [71:0] w, input logic [7:0] nv, input logic [7:0] it,
                      input logic [7:0] keep, input bit expect_out, output int acc);
    exp_t e;
    wait_ready();
    window_values    = w;
    neigh_addr_valid = nv;
    iterated_idx     = it;
    in_valid         = 1'b1;
    acc = cyc;
    if (expect_out) begin
      e = model(w, nv, it, keep);
      e.acc = acc;
      exp_q.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_monitor();
    exp_t e;
    logic [7:0] rem;
    rem = 8'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rem = 8'd0;
        continue;
      end
      if (out_valid) begin
        check("prev_pushes_done", rem, 0);
        check("out_valid_expected", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("compare_out", compare_out, e.cmp);
          check("equal_positions", equal_positions, e.eq);
          check("latency", cyc - e.acc, LAT);
          rem = e.push;
        end
      end
      if (push_valid && push_ready) begin
        check("push_expected", push_valid, rem != 0);
        if (rem != 0) begin
          check("push_idx", push_idx, lowest(rem));
          rem[push_idx] = 1'b0;
        end
      end
      if (flush) rem = 8'd0;
    end
  endtask

  task automatic run_main();
    int acc;
    reset_n = 1'b0; in_valid = 1'b0; window_values = '0; neigh_addr_valid = '0;
    iterated_idx = '0; flush = 1'b0; push_ready = 1'b0; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_compare_out", compare_out, 0);
    check("rst_equal_positions", equal_positions, 0);
    check("rst_push_valid", push_valid, 0);
    check("rst_push_idx", push_idx, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);

    // Centre 50 above all valid neighbours: no pushes, quick return to idle.
    pix = '{8'd10, 8'd15, 8'd20, 8'd25, 8'd50, 8'd30, 8'd35, 8'd40, 8'd12};
    send(pack_pix(), 8'hFF, 8'h00, 8'hFF, 1'b1, acc);
    wait_ready();
    check("ready_back", cyc - acc, LAT + 1);

    // Corners equal to centre: push 0 then 7.
    push_ready = 1'b1;
    pix = '{8'd50, 8'd20, 8'd20, 8'd20, 8'd50, 8'd20, 8'd20, 8'd20, 8'd50};
    send(pack_pix(), 8'hFF, 8'h00, 8'hFF, 1'b1, acc);
    wait_ready();

    // Large invalid neighbour is ignored.
    pix = '{8'd10, 8'd10, 8'd90, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
    send(pack_pix(), 8'hFB, 8'h00, 8'hFF, 1'b1, acc);
    wait_ready();

    // Stalled push whose index becomes iterated advances to 7.
    push_ready = 1'b0;
    pix = '{8'd50, 8'd20, 8'd20, 8'd20, 8'd50, 8'd20, 8'd20, 8'd20, 8'd50};
    send(pack_pix(), 8'hFF, 8'h00, 8'h80, 1'b1, acc);
    wait_push();
    check("stall_idx_first", push_idx, 0);
    step();
    @(negedge clk);
    check("stall_idx_hold", push_idx, 0);
    step();
    iterated_idx = 8'h01;
    @(negedge clk);
    check("stall_idx_adv", push_idx, 7);
    check("stall_valid_adv", push_valid, 1);
    step();
    push_ready = 1'b1;
    step();
    push_ready = 1'b0;
    wait_ready();
    iterated_idx = 8'h00;

    // Flush while pending 0x0C in PUSH.
    pix = '{8'd5, 8'd5, 8'd60, 8'd60, 8'd60, 8'd5, 8'd5, 8'd5, 8'd5};
    send(pack_pix(), 8'hFF, 8'h00, 8'hFF, 1'b1, acc);
    wait_push();
    check("flush_pending_idx", push_idx, 2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_push_valid", push_valid, 0);
    check("flush_in_ready", in_ready, 1);

    // Flush in CALC: the window never produces out_valid.
    pix = '{8'd10, 8'd15, 8'd20, 8'd25, 8'd50, 8'd30, 8'd35, 8'd40, 8'd12};
    send(pack_pix(), 8'hFF, 8'h00, 8'hFF, 1'b0, acc);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (6) step();
    check("calc_flush_in_ready", in_ready, 1);

    // Reset in CALC discards the window and clears outputs.
    send(pack_pix(), 8'hFF, 8'h00, 8'hFF, 1'b0, acc);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_compare_out", compare_out, 0);
    check("midrst_equal_positions", equal_positions, 0);
    check("midrst_push_valid", push_valid, 0);
    check("midrst_push_idx", push_idx, 0);
    step();
    reset_n = 1'b1;
    step();
    check("midrst_in_ready", in_ready, 1);
    repeat (4) step();

    // Randomized windows with small pixel range to provoke ties.
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 9; i++) pix[i] = 8'($urandom_range(0, 3));
      send(pack_pix(), 8'($urandom), 8'($urandom & $urandom), 8'hFF, 1'b1, acc);
    end
    rand_ready = 1'b0;
    push_ready = 1'b1;
    wait_ready();
    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    fork
      run_monitor();
      run_main();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eda_window_compare.md
EDA_WINDOW_COMPARE -- requirements
Module: eda_window_compare

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter WIN_K, default 3, window side; odd, 3..7; WINDOW_WIDTH=WIN_K*WIN_K, NEIGH=WINDOW_WIDTH-1, CENTER=(WINDOW_WIDTH-1)/2, IDX_W=$clog2(NEIGH) derived.
REQ-003 SHALL have ports: clk  input  1  clock; reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  window offered; in_ready  output  1  block can accept.
REQ-005 SHALL have window_values  input  PIXEL_WIDTH*WINDOW_WIDTH  pixels, position p at bits [p*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-006 SHALL have neigh_addr_valid  input  NEIGH  in-image neighbour mask; iterated_idx  input  NEIGH  already-visited mask (live, sampled every cycle).
REQ-007 SHALL have flush  input  1  abort pending pushes.
REQ-008 SHALL have out_valid  output  1  one-cycle result strobe; compare_out  output  1  centre is regional max candidate; equal_positions  output  NEIGH  valid neighbours equal to centre.
REQ-009 SHALL have push_valid  output  1, push_idx  output  IDX_W  neighbour index to enqueue, push_ready  input  1  consumer accepts.

Function
REQ-010 Neighbour index mapping SHALL be: position p<CENTER -> bit p; p>CENTER -> bit p-1; centre excluded.
REQ-011 A window SHALL be accepted on the cycle in_valid && in_ready; inputs registered on acceptance.
REQ-012 FSM states SHALL be IDLE, CALC, PUSH; IDLE->CALC on accept; CALC->PUSH when result ready; PUSH->IDLE when pending mask is zero or flush.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 Max SHALL be taken over valid neighbours only; neighbours with neigh_addr_valid=0 contribute 0.
REQ-015 compare_out SHALL be 1 iff centre >= max of valid neighbours (unsigned); 1 if no valid neighbours.
REQ-016 equal_positions SHALL be (neighbour==centre) & neigh_addr_valid, held stable from out_valid until next accept.
REQ-017 Latency accept->out_valid SHALL be 2 cycles (3 with REQ-027 macro); out_valid high exactly 1 cycle.
REQ-018 On entering PUSH, pending SHALL load equal_positions; each cycle pending SHALL be ANDed with ~iterated_idx.
REQ-019 push_valid SHALL be 1 in PUSH when pending!=0; push_idx SHALL be the lowest set bit of pending & ~iterated_idx.
REQ-020 On push_valid && push_ready the pushed bit SHALL clear next cycle; each index SHALL be pushed at most once per window.
REQ-021 push_idx SHALL hold stable while push_valid && !push_ready unless that bit becomes iterated, then advance to the next lowest bit.
REQ-022 flush SHALL clear pending and return to IDLE next cycle from any state; no out_valid for a window flushed in CALC.
REQ-023 If equal_positions is zero, PUSH SHALL exit to IDLE after 1 cycle with no push_valid.

Reset
REQ-024 On reset_n low SHALL: state IDLE, in_ready 1 after release, out_valid 0, compare_out 0, equal_positions 0, push_valid 0, push_idx 0, pending 0.
REQ-025 Reset mid-operation SHALL discard the window and all pending pushes.

Configuration
REQ-026 Macro EDA_WINDOW_COMPARE_PIPE_EN SHALL be the only compile option.
REQ-027 With it defined, a register stage SHALL split the max tree at its middle level (latency 3); without it the tree is single-cycle combinational after input register (latency 2); functional results identical.

Structure
REQ-028 Package eda_pkg SHALL hold the FSM state enum, default PIXEL_WIDTH/WIN_K and lowest-set-bit function.
REQ-029 Max tree SHALL use sub-module eda_max_tree (parametrised N inputs, PIXEL_WIDTH, optional mid register).

Verification
REQ-030 K=3, centre 50, neighbours 10..40 all valid -> compare_out 1, equal_positions 0, no pushes, in_ready back after 3 cycles.
REQ-031 Centre 50, positions 0 and 8 = 50, rest 20, iterated 0, push_ready 1 -> equal_positions 0x81, push_idx 0 then 7.
REQ-032 Position 2 = 90 with neigh_addr_valid bit2=0, others 10 -> compare_out 1.
REQ-033 equal 0x81, push_ready 0 three cycles, iterated_idx bit0 set cycle 2 -> push_idx 0 then 7, only 7 pushed.
REQ-034 flush during PUSH with pending 0x0C -> push_valid 0 next cycle, in_ready 1.
REQ-035 reset_n low in CALC -> out_valid never asserted, all outputs 0; repeat 030 with EDA_WINDOW_COMPARE_PIPE_EN, K=5 -> latency 3.
